add_sequencer: RTL and testbench

ADD_SEQUENCER -- requirements
Module: add_sequencer

---
 rtl/add_sequencer_if.sv | 29 ++
 rtl/add_sequencer.sv | 113 +++++++++++
 tb/tb_add_sequencer.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/add_sequencer_if.sv
// Handshake and operand bundle for add_sequencer: the master issues start plus operands,
// the slave returns busy/done and the registered result.
interface add_sequencer_if #(
   parameter int N     = 4,
   parameter int WORDS = 4
);
   localparam int W = N * WORDS;

   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         c_in;
   logic         sub;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         c_out;
   logic         overflow;

   modport master (
      output start, a, b, c_in, sub,
      input  busy, done, sum, c_out, overflow
   );

   modport slave (
      input  start, a, b, c_in, sub,
      output busy, done, sum, c_out, overflow
   );
endinterface

// File: rtl/add_sequencer.sv
// Serial W-bit adder/subtractor: one N-bit adder slice is reused for WORDS cycles,
// least-significant slice first, with the carry held in a register between slices.
module add_sequencer #(
   parameter int N     = 4,
   parameter int WORDS = 4
) (
   input logic           clk,
   input logic           reset,
   add_sequencer_if.slave bus
);
   localparam int W  = N * WORDS;
   localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t        state;
   logic [W-1:0]  op_a;
   logic [W-1:0]  op_b;
   logic [W-1:0]  acc;
   logic          carry;
   logic          op_sub;
   logic [IW-1:0] idx;

   logic          busy_q;
   logic          done_q;
   logic [W-1:0]  sum_q;
   logic          c_out_q;
   logic          overflow_q;

   logic [N-1:0]  slice_x;
   logic [N-1:0]  slice_y;
   logic [N-1:0]  slice_word;
   logic          slice_carry;
   logic [W-1:0]  next_acc;
   logic          next_overflow;

   // The single shared slice adder, fed by the slice selected by idx.
   always_comb begin
      slice_x = op_a[int'(idx) * N +: N];
      slice_y = op_b[int'(idx) * N +: N];
      {slice_carry, slice_word} = {1'b0, slice_x} + {1'b0, slice_y} + {{N{1'b0}}, carry};
   end

   // Accumulator with the current slice merged in; on the last slice this is the full result.
   // op_b already holds ~b for a subtract, so the overflow rule is the same for both operations.
   always_comb begin
      next_acc = acc;
      next_acc[int'(idx) * N +: N] = slice_word;
      next_overflow = (op_a[W-1] == op_b[W-1]) && (next_acc[W-1] != op_a[W-1]);
   end

   // Control FSM and datapath registers; all outputs come straight from flops.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         op_a       <= '0;
         op_b       <= '0;
         acc        <= '0;
         carry      <= 1'b0;
         op_sub     <= 1'b0;
         idx        <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         sum_q      <= '0;
         c_out_q    <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  op_a   <= bus.a;
                  op_b   <= bus.sub ? ~bus.b : bus.b;
                  carry  <= bus.sub ? 1'b1 : bus.c_in;
                  op_sub <= bus.sub;
                  idx    <= '0;
                  busy_q <= 1'b1;
                  state  <= RUN;
               end
            end
            RUN: begin
               acc   <= next_acc;
               carry <= slice_carry;
               if (idx == LAST_IDX) begin
                  sum_q      <= next_acc;
                  c_out_q    <= slice_carry;
                  overflow_q <= next_overflow;
                  done_q     <= 1'b1;
                  state      <= DONE;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            DONE: begin
               done_q <= 1'b0;
               busy_q <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.sum      = sum_q;
   assign bus.c_out    = c_out_q;
   assign bus.overflow = overflow_q;

   // op_sub records the operation kind for debug visibility; the datapath itself works from op_b.
   logic unused_ok;
   assign unused_ok = op_sub;
endmodule

// File: tb/tb_add_sequencer.sv
// Scoreboard bench for add_sequencer (N=4, WORDS=4): directed corner cases plus random
// operations, checked at each done pulse against a 17-bit arithmetic reference.
module tb_add_sequencer;
   localparam int N     = 4;
   localparam int WORDS = 4;
   localparam int W     = N * WORDS;

   typedef struct {
      logic [W-1:0] sum;
      logic         c_out;
      logic         overflow;
   } result_t;

   logic clk;
   logic reset;
   int   compared;
   int   mismatched;
   result_t sb[$];

   add_sequencer_if #(.N(N), .WORDS(WORDS)) bus ();

   add_sequencer #(.N(N), .WORDS(WORDS)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: plain W+1-bit arithmetic; subtract reports c_out as "no borrow".
   function automatic result_t refModel(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic c_in, input logic sub);
      result_t   r;
      logic [W:0] full;
      if (sub) begin
         full       = {1'b0, a} - {1'b0, b};
         r.sum      = full[W-1:0];
         r.c_out    = (a >= b);
         r.overflow = (a[W-1] != b[W-1]) && (r.sum[W-1] != a[W-1]);
      end else begin
         full       = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c_in};
         r.sum      = full[W-1:0];
         r.c_out    = full[W];
         r.overflow = (a[W-1] == b[W-1]) && (r.sum[W-1] != a[W-1]);
      end
      return r;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Drives start at the current (negedge) time, then scrambles the operands after the accept edge.
   task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic c_in, input logic sub, input bit expect_result);
      bus.start = 1'b1;
      bus.a     = a;
      bus.b     = b;
      bus.c_in  = c_in;
      bus.sub   = sub;
      if (expect_result) sb.push_back(refModel(a, b, c_in, sub));
      @(negedge clk);
      bus.start = 1'b0;
      bus.a     = W'($urandom);
      bus.b     = W'($urandom);
      bus.c_in  = 1'($urandom);
      bus.sub   = 1'($urandom);
   endtask

   task automatic waitIdle();
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (bus.busy === 1'b0) return;
      end
      compared++;
      mismatched++;
      $display("[TB] FAIL wait_idle: busy still 1, expected 0 within 50 cycles");
   endtask

   task automatic waitDone();
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (bus.done === 1'b1) return;
      end
      compared++;
      mismatched++;
      $display("[TB] FAIL wait_done: done never 1, expected 1 within 50 cycles");
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   initial begin
      result_t e;
      forever begin
         @(negedge clk);
         if (bus.done === 1'b1) begin
            if (sb.size() == 0) begin
               compared++;
               mismatched++;
               $display("[TB] FAIL unexpected_done: done=1 with no operation outstanding at %0t", $time);
            end else begin
               e = sb.pop_front();
               checkOutput("sum", 32'(bus.sum), 32'(e.sum));
               checkOutput("c_out", 32'(bus.c_out), 32'(e.c_out));
               checkOutput("overflow", 32'(bus.overflow), 32'(e.overflow));
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int done_seen;
      logic [W-1:0] ra, rb;
      compared   = 0;
      mismatched = 0;
      reset      = 1'b1;
      bus.start  = 1'b0;
      bus.a      = '0;
      bus.b      = '0;
      bus.c_in   = 1'b0;
      bus.sub    = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("reset_busy", 32'(bus.busy), 32'd0);
      checkOutput("reset_done", 32'(bus.done), 32'd0);
      checkOutput("reset_sum", 32'(bus.sum), 32'd0);
      checkOutput("reset_c_out", 32'(bus.c_out), 32'd0);
      checkOutput("reset_overflow", 32'(bus.overflow), 32'd0);
      reset = 1'b0;
      @(negedge clk);

      $display("[TB] wrap-around add with latency check");
      applyStimulus(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1);
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         checkOutput($sformatf("busy_edge%0d", k), 32'(bus.busy), (k <= 4) ? 32'd1 : 32'd0);
         checkOutput($sformatf("done_edge%0d", k), 32'(bus.done), (k == 4) ? 32'd1 : 32'd0);
      end

      $display("[TB] directed add/sub cases");
      waitIdle();
      applyStimulus(16'h1234, 16'h4321, 1'b1, 1'b0, 1'b1);
      waitDone();
      waitIdle();
      applyStimulus(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1);
      waitDone();
      waitIdle();
      applyStimulus(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b1);
      waitDone();

      $display("[TB] start while busy is ignored, start right after done is accepted");
      waitIdle();
      applyStimulus(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      applyStimulus(16'hAAAA, 16'h5555, 1'b1, 1'b0, 1'b0);
      done_seen = 0;
      for (int i = 0; i < 12; i++) begin
         if (bus.done === 1'b1) begin
            done_seen++;
            break;
         end
         @(negedge clk);
      end
      checkOutput("single_done", 32'(done_seen), 32'd1);
      @(negedge clk);
      checkOutput("idle_after_done", 32'(bus.busy), 32'd0);
      applyStimulus(16'h0F0F, 16'h00F1, 1'b0, 1'b0, 1'b1);
      checkOutput("accept_after_done", 32'(bus.busy), 32'd1);
      waitDone();

      $display("[TB] reset mid-operation");
      waitIdle();
      applyStimulus(16'h2468, 16'h1357, 1'b0, 1'b0, 1'b0);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checkOutput("abort_busy", 32'(bus.busy), 32'd0);
      checkOutput("abort_done", 32'(bus.done), 32'd0);
      checkOutput("abort_sum", 32'(bus.sum), 32'd0);
      done_seen = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (bus.done === 1'b1) done_seen++;
      end
      checkOutput("abort_no_done", 32'(done_seen), 32'd0);

      $display("[TB] random operations");
      for (int n = 0; n < 1000; n++) begin
         waitIdle();
         repeat ($urandom_range(0, 1)) @(negedge clk);
         case ($urandom_range(0, 7))
            0: ra = 16'hFFFF;
            1: ra = 16'h8000;
            2: ra = 16'h7FFF;
            default: ra = W'($urandom);
         endcase
         case ($urandom_range(0, 7))
            0: rb = 16'hFFFF;
            1: rb = 16'h8000;
            2: rb = 16'h0000;
            default: rb = W'($urandom);
         endcase
         applyStimulus(ra, rb, 1'($urandom), 1'($urandom), 1'b1);
      end
      waitIdle();
      repeat (3) @(negedge clk);
      checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
